pht_table: RTL
==============

Name: pht_table

Overview:
- Pattern history table storing one 2-bit saturating-counter state per branch index.
- Serves the counter FSM in both directions:
  - Read side: supplies the current state, which becomes the FSM's in_data.
  - Write side: accepts the FSM's write-back (its wr_en / out_data), with the index delayed by the requester.
- After every reset it runs an init sweep that loads every entry with the initial state before it accepts traffic.

Parameters:
- IDX_W, 6, index width; table depth = 2^IDX_W entries.
- DATA_W, 2, entry width; encoding 00 WELL_NTAKEN, 01 NTAKEN, 10 TAKEN, 11 WELL_TAKEN.
- INIT_VAL, 2'b10, value loaded by the init sweep (TAKEN, matching the FSM's taken-biased reset prediction).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request, sampled each cycle.
- rd_idx  in  IDX_W  read index.
- rd_vld  out  1  rd_data valid; one-cycle pulse per accepted read.
- rd_data  out  DATA_W  registered entry contents.
- wr_en  in  1  write-back strobe from the counter FSM.
- wr_idx  in  IDX_W  write index.
- wr_data  in  DATA_W  new counter state.
- busy  out  1  high while reset is asserted or the init sweep is running.
- par_err  out  1  parity error pulse (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: rd_vld=0, rd_data=INIT_VAL, busy=1, par_err=0.
  - State machine goes to S_INIT with sweep counter = 0.
  - Array contents are not cleared by reset itself.
- State machine, two states:
  - S_INIT: each cycle write INIT_VAL to entry[sweep_cnt] and increment sweep_cnt. When sweep_cnt == 2^IDX_W-1 is written, go to S_RUN.
    - busy = 1 for exactly 2^IDX_W cycles after reset release.
    - busy is registered; it falls on the edge that completes the last sweep write.
  - S_RUN: normal operation; busy = 0. There is no return to S_INIT except via reset.
- Reads in S_RUN:
  - rd_req=1 at edge N: rd_vld=1 and rd_data=entry[rd_idx] after edge N (1-cycle latency).
  - rd_req=0: rd_vld=0 next cycle; rd_data holds its last value.
  - Back-to-back reads every cycle are supported (full throughput).
- Writes in S_RUN:
  - wr_en=1: entry[wr_idx] <= wr_data at the edge.
  - One write per cycle; no backpressure.
- Simultaneous read and write:
  - Same index: write-first bypass; rd_data returns wr_data in the same 1-cycle latency.
  - Different index: both proceed independently.
- During S_INIT:
  - rd_req is ignored: no rd_vld pulse, and the request is not queued.
  - wr_en is dropped; the sweep value wins.
  - The requester must hold off while busy=1.
- Reset asserted mid-sweep or mid-run: immediate abort, outputs to reset values, sweep restarts from index 0 after release.
- Index wrap:
  - sweep_cnt is IDX_W+1 bits wide or has a terminal compare, so there is no wrap into a second sweep.
  - rd_idx and wr_idx cover the full 0..2^IDX_W-1 range; nothing is out of range.
- Storage: inferred register array, synchronous write, registered read output. No reset on array cells; the sweep provides initialisation.

Optional Feature:
- Macro: PHT_PARITY_EN.
- Defined:
  - Each entry stores DATA_W+1 bits; the extra bit is even parity over data, computed on every write, sweep included.
  - On an accepted read, parity is checked on the stored word (the bypass path is exempt).
  - On mismatch: rd_data = INIT_VAL instead of the stored value, and par_err = 1 for the rd_vld cycle.
  - The entry is not auto-corrected; the next write-back repairs it.
- Not defined:
  - Entries are DATA_W bits.
  - par_err is tied to 0.
  - Read path identical otherwise.

Test Plan:
- Reset pulse low 3 cycles, then release; count busy cycles -> busy=1 for exactly 64 cycles after release. Then read indices 0, 31, 63 -> rd_data=2'b10 each, with rd_vld one cycle after each rd_req.
- After init, write idx 5 = 2'b00, then read idx 5 next cycle -> rd_data=2'b00; read idx 6 -> rd_data=2'b10.
- Same cycle: wr_en=1, wr_idx=9, wr_data=2'b11, rd_req=1, rd_idx=9 -> next cycle rd_vld=1, rd_data=2'b11. Repeat with rd_idx=10 -> rd_data=2'b10.
- During the sweep, issue rd_req=1 and wr_en=1 (idx 3, data 2'b00) at cycle 10 -> no rd_vld pulse. After busy=0, read idx 3 -> 2'b10.
- Assert reset at sweep cycle 20 and at run time after writing idx 7 = 2'b01 -> outputs go to reset values asynchronously. Sweep reruns 64 cycles, then idx 7 reads 2'b10.
- With PHT_PARITY_EN: force-flip the stored parity bit of idx 12, then read idx 12 -> rd_data=2'b10, par_err=1 for one cycle. Without the macro, par_err stays 0 throughout all tests.

Source files
------------

// File: rtl/pht_table.sv
// Pattern history table of 2-bit saturating-counter states with a post-reset init sweep.
// Optional parity protection of stored entries is enabled by defining PHT_PARITY_EN.
module pht_table #(
   parameter int                IDX_W    = 6,
   parameter int                DATA_W   = 2,
   parameter logic [DATA_W-1:0] INIT_VAL = 2'b10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_vld,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              par_err
);

`ifdef PHT_PARITY_EN
   localparam int EW = DATA_W + 1;
`else
   localparam int EW = DATA_W;
`endif
   localparam int               DEPTH    = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Stored word: even parity bit on top of the data when protection is enabled.
   function automatic logic [EW-1:0] encode_word(input logic [DATA_W-1:0] d);
`ifdef PHT_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    sweep_q, sweep_d;
   logic                busy_q, busy_d;
   logic                rd_vld_q, rd_vld_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                par_err_q, par_err_d;

   logic [EW-1:0]       mem_q [DEPTH];
   logic                mem_we_s;
   logic [IDX_W-1:0]    mem_widx_s;
   logic [EW-1:0]       mem_wword_s;
   logic [EW-1:0]       rd_word_s;

   // Next-state, array write port selection and read-path result.
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      busy_d      = busy_q;
      rd_vld_d    = 1'b0;
      rd_data_d   = rd_data_q;
      par_err_d   = 1'b0;
      mem_we_s    = 1'b0;
      mem_widx_s  = wr_idx;
      mem_wword_s = encode_word(wr_data);
      rd_word_s   = mem_q[rd_idx];

      case (state_q)
         S_INIT: begin
            // Sweep owns the write port; requester traffic is dropped.
            mem_we_s    = 1'b1;
            mem_widx_s  = sweep_q;
            mem_wword_s = encode_word(INIT_VAL);
            if (sweep_q == LAST_IDX) begin
               state_d = S_RUN;
               busy_d  = 1'b0;
            end else begin
               sweep_d = sweep_q + IDX_ONE;
            end
         end
         S_RUN: begin
            mem_we_s = wr_en;
            busy_d   = 1'b0;
            if (rd_req) begin
               rd_vld_d = 1'b1;
               if (wr_en && (wr_idx == rd_idx)) begin
                  rd_data_d = wr_data;
               end else begin
`ifdef PHT_PARITY_EN
                  if (^rd_word_s) begin
                     rd_data_d = INIT_VAL;
                     par_err_d = 1'b1;
                  end else begin
                     rd_data_d = rd_word_s[DATA_W-1:0];
                  end
`else
                  rd_data_d = rd_word_s[DATA_W-1:0];
`endif
               end
            end else begin
               rd_vld_d = 1'b0;
            end
         end
         default: begin
            state_d = S_INIT;
            sweep_d = {IDX_W{1'b0}};
            busy_d  = 1'b1;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_INIT;
         sweep_q   <= {IDX_W{1'b0}};
         busy_q    <= 1'b1;
         rd_vld_q  <= 1'b0;
         rd_data_q <= INIT_VAL;
         par_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         busy_q    <= busy_d;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
         par_err_q <= par_err_d;
      end
   end

   // Storage cells carry no reset; the sweep initialises them.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_widx_s] <= mem_wword_s;
      end
   end

   assign rd_vld  = rd_vld_q;
   assign rd_data = rd_data_q;
   assign busy    = busy_q;
   assign par_err = par_err_q;

endmodule
